line_memory_model: RTL and testbench
====================================

# line_memory_model

Behavioural backing store for the data cache: 512 lines of 256 bits with a fixed multi-cycle access latency and a request/acknowledge handshake. It sits directly downstream of the CPU's data cache and serves line fills and write-backs on the CPU's memory port. It also serves as the memory model the top-level bench preloads and dumps. Per-direction access counters are provided for bench-side checking of cache traffic.

## Interface
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255
- DEPTH, 512, number of 256-bit lines; power of two
- LINE_W, 256, line width in bits
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- addr_i  input  32  byte address; line index = addr_i[13:5]; bits [4:0] and [31:14] ignored
- data_i  input  LINE_W  write line
- enable_i  input  1  request valid
- write_i  input  1  1 = write, 0 = read; sampled with enable_i
- ack_o  output  1  one-cycle completion pulse
- data_o  output  LINE_W  read line, valid while ack_o is high, held afterwards
- rd_cnt_o  output  16  completed reads, saturating at 16'hFFFF
- wr_cnt_o  output  16  completed writes, saturating at 16'hFFFF

## Operation
- Storage is an array of DEPTH x LINE_W named memory. It is not cleared by reset; the bench initialises and inspects it hierarchically.
- FSM states:
  - IDLE -> WAIT when enable_i=1 at a rising edge. addr_i[13:5], data_i and write_i are latched at that edge and the latency counter is loaded to 1.
  - WAIT: the counter increments each edge. When counter = LATENCY the FSM moves to ACK.
  - ACK -> IDLE unconditionally after one cycle. enable_i is not sampled in ACK.
- Transition into ACK performs the access:
  - Read: data_o <= memory[idx]; rd_cnt_o increments.
  - Write: memory[idx] <= latched data; wr_cnt_o increments; data_o unchanged.
- LATENCY=1: IDLE -> ACK directly at the edge after acceptance. WAIT is skipped.
- Inputs are ignored while in WAIT or ACK. Changing addr_i, data_i or write_i, or dropping enable_i after acceptance, does not affect the latched request. The request completes and ack_o still pulses.
- The master must deassert enable_i in the cycle after ack_o. If enable_i is still high in IDLE, it is treated as a new request.
- Address wrap: indices above DEPTH-1 cannot occur; upper address bits alias to the same line.
- Counters saturate and never wrap.

## Timing
- Reset values: ack_o=0, data_o=0, rd_cnt_o=0, wr_cnt_o=0, FSM=IDLE, counter=0.
- Acceptance edge E0:
  - ack_o is high from edge E(LATENCY) to E(LATENCY+1).
  - Read data is visible on data_o in the same cycle as ack_o.
  - For a write, memory reflects the new line from E(LATENCY) onward.
- The earliest next acceptance is E(LATENCY+2). Back-to-back throughput is one request per LATENCY+2 cycles.
- Reset asserted mid-request (WAIT or ACK): outputs and FSM go to reset values immediately.
  - A write that has not reached E(LATENCY) is discarded; memory is unchanged.
  - A completed write is retained.
- Read after write to the same line returns the new data, given request ordering.
- ack_o is registered; no combinational path from any input to any output.

## Test plan
- Read hit on preloaded line: memory[1]=256'h8888_9999_..._0000, enable_i=1, write_i=0, addr_i=32'h20 at E0 -> ack_o high exactly in cycle 10 (LATENCY=10), data_o=memory[1], rd_cnt_o=1.
- Write then read: write 256'hECFA...ECFA to addr 32'h240, then read 32'h240 -> write ack at E10, read accepted no earlier than E12, read returns ECFA pattern, wr_cnt_o=1, rd_cnt_o=1.
- Input churn: after acceptance at addr 32'h400, change addr_i to 32'h0 and drop enable_i at E2 -> ack still at E10 with data_o=memory[32].
- Aliasing: read addr 32'h0000_4020 with memory[1] preloaded -> returns memory[1]; low 5 address bits 5'h1F give the same result.
- Reset mid-write: write to 32'h440 accepted at E0, rst_i pulsed between E5 and E6 -> ack_o never asserts, memory[34] unchanged, counters 0, new request accepted after reset release.
- LATENCY=1 and saturation: with LATENCY=1, ack_o arrives at E1 and the next acceptance is at E3. With rd_cnt_o forced to 16'hFFFE, two reads leave rd_cnt_o at 16'hFFFF.

Source files
------------

// File: rtl/line_memory_model_if.sv
// Request/acknowledge bus between the data cache memory port and the line store.
//   addr_i   : byte address of the line (master -> slave)
//   data_i   : line to write (master -> slave)
//   enable_i : request valid (master -> slave)
//   write_i  : 1 = write, 0 = read, sampled with enable_i (master -> slave)
//   ack_o    : one-cycle completion pulse (slave -> master)
//   data_o   : read line, valid with ack_o and held afterwards (slave -> master)
//   rd_cnt_o : saturating count of completed reads (slave -> master)
//   wr_cnt_o : saturating count of completed writes (slave -> master)
interface line_memory_model_if #(
  parameter int unsigned LINE_W = 256
);
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic [15:0]       rd_cnt_o;
  logic [15:0]       wr_cnt_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, rd_cnt_o, wr_cnt_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, rd_cnt_o, wr_cnt_o
  );
endinterface

// File: rtl/line_memory_model.sv
// Line-granular backing store behind the data cache with a fixed access latency.
// A request is latched at acceptance, the access happens on the edge that
// raises ack_o, and the bus is idle again one cycle later.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : asynchronous active-high reset (storage array is not cleared)
//   bus   : slave side of line_memory_model_if (request, ack, read data, counters)
module line_memory_model #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LINE_W  = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  line_memory_model_if.slave bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ACC_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] data;
    logic              write;
  } req_t;

  logic [LINE_W-1:0] memory [DEPTH];

  state_t            state_q;
  state_t            state_d;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic [LINE_W-1:0] data_q;
  logic [ACC_W-1:0]  rd_cnt_q;
  logic [ACC_W-1:0]  wr_cnt_q;
  logic              accept_c;
  logic              access_c;

  // Offset and high address bits do not select a line; they alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[ADDR_W-1:OFF_W+IDX_W], bus.addr_i[OFF_W-1:0]};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The cycle after acceptance is always spent in WAIT, so with
  // LATENCY=1 the access still lands on the edge after acceptance.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    access_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          accept_c = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY)) begin
          access_c = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latch, latency counter, read data and access counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      data_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      ack_q <= access_c;
      if (accept_c) begin
        req_q.idx   <= bus.addr_i[OFF_W +: IDX_W];
        req_q.data  <= bus.data_i;
        req_q.write <= bus.write_i;
        cnt_q       <= CNT_W'(1);
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (access_c && !req_q.write) begin
        data_q <= memory[req_q.idx];
        if (rd_cnt_q != '1) begin
          rd_cnt_q <= rd_cnt_q + ACC_W'(1);
        end
      end
      if (access_c && req_q.write) begin
        if (wr_cnt_q != '1) begin
          wr_cnt_q <= wr_cnt_q + ACC_W'(1);
        end
      end
    end
  end

  // Storage write. access_c is only ever set in WAIT, and reset forces IDLE
  // asynchronously, so an interrupted write never reaches the array.
  always_ff @(posedge clk_i) begin
    if (access_c && req_q.write) begin
      memory[req_q.idx] <= req_q.data;
    end
  end

  assign bus.ack_o    = ack_q;
  assign bus.data_o   = data_q;
  assign bus.rd_cnt_o = rd_cnt_q;
  assign bus.wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_line_memory_model.sv
// Directed bench for line_memory_model: one instance at LATENCY=10 for the
// main scenarios, one at LATENCY=1 for the short-latency and saturation case.
module tb_line_memory_model;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned LAT_A  = 10;
  localparam int unsigned LAT_B  = 1;
  localparam int          LIMIT  = 40;

  localparam logic [LINE_W-1:0] P1 = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [LINE_W-1:0] ECFA = {16{16'hECFA}};
  localparam logic [LINE_W-1:0] P0   = {8{32'h0000_A5A5}};
  localparam logic [LINE_W-1:0] P18  = {8{32'h1818_1818}};
  localparam logic [LINE_W-1:0] P32  = {8{32'h3232_0020}};
  localparam logic [LINE_W-1:0] P34  = {8{32'h3434_0022}};
  localparam logic [LINE_W-1:0] NEWD = {8{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] PB3  = {4{64'h0123_4567_89AB_CDEF}};

  logic clk_i = 1'b0;
  logic rst_i;

  int n_checks = 0;
  int n_fail   = 0;

  line_memory_model_if #(.LINE_W(LINE_W)) bus_a ();
  line_memory_model_if #(.LINE_W(LINE_W)) bus_b ();

  line_memory_model #(.LATENCY(LAT_A), .DEPTH(512), .LINE_W(LINE_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_a.slave)
  );

  line_memory_model #(.LATENCY(LAT_B), .DEPTH(512), .LINE_W(LINE_W)) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_b.slave)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Issue one request on bus_a, drop enable right after acceptance and
  // return the number of edges from acceptance to ack (-1 if none).
  task automatic run_req_a(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                           input logic wr, output int lat);
    @(negedge clk_i);
    bus_a.addr_i   = addr;
    bus_a.data_i   = data;
    bus_a.write_i  = wr;
    bus_a.enable_i = 1'b1;
    @(posedge clk_i); #1;
    bus_a.enable_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk_i); #1;
      if (bus_a.ack_o === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i          = 1'b1;
    bus_a.addr_i   = '0;
    bus_a.data_i   = '0;
    bus_a.write_i  = 1'b0;
    bus_a.enable_i = 1'b0;
    bus_b.addr_i   = '0;
    bus_b.data_i   = '0;
    bus_b.write_i  = 1'b0;
    bus_b.enable_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (bus_a.ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus_a.ack_o); end
    n_checks++;
    if (bus_a.data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus_a.data_o); end
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_rd_cnt: got %h expected 0", bus_a.rd_cnt_o); end
    n_checks++;
    if (bus_a.wr_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_wr_cnt: got %h expected 0", bus_a.wr_cnt_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (bus_a.ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_ack: got %b expected 0", bus_a.ack_o); end
  endtask

  task automatic test_read_hit();
    int lat;
    run_req_a(32'h0000_0020, '0, 1'b0, lat);
    n_checks++;
    if (lat != 10) begin n_fail++; $display("FAIL read_hit_latency: got %0d expected 10", lat); end
    n_checks++;
    if (bus_a.data_o !== P1) begin n_fail++; $display("FAIL read_hit_data: got %h expected %h", bus_a.data_o, P1); end
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'd1) begin n_fail++; $display("FAIL read_hit_rd_cnt: got %0d expected 1", bus_a.rd_cnt_o); end
    @(posedge clk_i); #1;
    n_checks++;
    if (bus_a.ack_o !== 1'b0) begin n_fail++; $display("FAIL read_hit_ack_pulse: got %b expected 0", bus_a.ack_o); end
    n_checks++;
    if (bus_a.data_o !== P1) begin n_fail++; $display("FAIL read_hit_data_held: got %h expected %h", bus_a.data_o, P1); end
  endtask

  // Write then read the same line with enable held high the whole time: the
  // read is taken at the second edge after the write ack.
  task automatic test_back_to_back();
    int lat;
    int lat2;
    @(negedge clk_i);
    bus_a.addr_i   = 32'h0000_0240;
    bus_a.data_i   = ECFA;
    bus_a.write_i  = 1'b1;
    bus_a.enable_i = 1'b1;
    @(posedge clk_i); #1;
    lat = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk_i); #1;
      if (k == 9) begin
        n_checks++;
        if (dut.memory[18] !== P18) begin n_fail++; $display("FAIL b2b_mem_before_ack: got %h expected %h", dut.memory[18], P18); end
      end
      if (bus_a.ack_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != 10) begin n_fail++; $display("FAIL b2b_write_latency: got %0d expected 10", lat); end
    n_checks++;
    if (dut.memory[18] !== ECFA) begin n_fail++; $display("FAIL b2b_mem_written: got %h expected %h", dut.memory[18], ECFA); end
    n_checks++;
    if (bus_a.wr_cnt_o !== 16'd1) begin n_fail++; $display("FAIL b2b_wr_cnt: got %0d expected 1", bus_a.wr_cnt_o); end
    n_checks++;
    if (bus_a.data_o !== P1) begin n_fail++; $display("FAIL b2b_write_keeps_data: got %h expected %h", bus_a.data_o, P1); end
    bus_a.write_i = 1'b0;
    bus_a.data_i  = '0;
    lat2 = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk_i); #1;
      if (k == 2) bus_a.enable_i = 1'b0;
      if (bus_a.ack_o === 1'b1) begin
        lat2 = k;
        break;
      end
    end
    n_checks++;
    if (lat2 != 12) begin n_fail++; $display("FAIL b2b_read_spacing: got %0d expected 12", lat2); end
    n_checks++;
    if (bus_a.data_o !== ECFA) begin n_fail++; $display("FAIL b2b_read_data: got %h expected %h", bus_a.data_o, ECFA); end
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'd2) begin n_fail++; $display("FAIL b2b_rd_cnt: got %0d expected 2", bus_a.rd_cnt_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_input_churn();
    int lat;
    @(negedge clk_i);
    bus_a.addr_i   = 32'h0000_0400;
    bus_a.data_i   = '0;
    bus_a.write_i  = 1'b0;
    bus_a.enable_i = 1'b1;
    @(posedge clk_i); #1;
    lat = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk_i); #1;
      if (k == 2) begin
        bus_a.addr_i   = 32'h0;
        bus_a.enable_i = 1'b0;
        bus_a.write_i  = 1'b1;
        bus_a.data_i   = NEWD;
      end
      if (bus_a.ack_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != 10) begin n_fail++; $display("FAIL churn_latency: got %0d expected 10", lat); end
    n_checks++;
    if (bus_a.data_o !== P32) begin n_fail++; $display("FAIL churn_data: got %h expected %h", bus_a.data_o, P32); end
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'd3 || bus_a.wr_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL churn_counts: got rd=%0d wr=%0d expected rd=3 wr=1", bus_a.rd_cnt_o, bus_a.wr_cnt_o);
    end
    n_checks++;
    if (dut.memory[0] !== P0) begin n_fail++; $display("FAIL churn_mem0: got %h expected %h", dut.memory[0], P0); end
    @(posedge clk_i); #1;
    bus_a.write_i = 1'b0;
    bus_a.data_i  = '0;
  endtask

  task automatic test_aliasing();
    int lat;
    run_req_a(32'h0000_4020, '0, 1'b0, lat);
    n_checks++;
    if (lat != 10 || bus_a.data_o !== P1) begin
      n_fail++; $display("FAIL alias_high_bits: got lat=%0d data=%h expected lat=10 data=%h", lat, bus_a.data_o, P1);
    end
    @(posedge clk_i); #1;
    run_req_a(32'h0000_0240, '0, 1'b0, lat);
    n_checks++;
    if (bus_a.data_o !== ECFA) begin n_fail++; $display("FAIL alias_interleave: got %h expected %h", bus_a.data_o, ECFA); end
    @(posedge clk_i); #1;
    run_req_a(32'h0000_403F, '0, 1'b0, lat);
    n_checks++;
    if (lat != 10 || bus_a.data_o !== P1) begin
      n_fail++; $display("FAIL alias_low_bits: got lat=%0d data=%h expected lat=10 data=%h", lat, bus_a.data_o, P1);
    end
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'd6) begin n_fail++; $display("FAIL alias_rd_cnt: got %0d expected 6", bus_a.rd_cnt_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_write();
    int lat;
    int seen;
    @(negedge clk_i);
    bus_a.addr_i   = 32'h0000_0440;
    bus_a.data_i   = NEWD;
    bus_a.write_i  = 1'b1;
    bus_a.enable_i = 1'b1;
    @(posedge clk_i); #1;
    bus_a.enable_i = 1'b0;
    bus_a.write_i  = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'h0 || bus_a.wr_cnt_o !== 16'h0 || bus_a.data_o !== '0) begin
      n_fail++; $display("FAIL midrst_async_clear: got rd=%0d wr=%0d data=%h expected all 0", bus_a.rd_cnt_o, bus_a.wr_cnt_o, bus_a.data_o);
    end
    #4;
    rst_i = 1'b0;
    seen = 0;
    for (int k = 6; k <= 16; k++) begin
      @(posedge clk_i); #1;
      if (bus_a.ack_o === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d expected 0", seen); end
    n_checks++;
    if (dut.memory[34] !== P34) begin n_fail++; $display("FAIL midrst_mem_kept: got %h expected %h", dut.memory[34], P34); end
    n_checks++;
    if (dut.memory[18] !== ECFA) begin n_fail++; $display("FAIL midrst_done_write_kept: got %h expected %h", dut.memory[18], ECFA); end
    run_req_a(32'h0000_0440, '0, 1'b0, lat);
    n_checks++;
    if (lat != 10 || bus_a.data_o !== P34) begin
      n_fail++; $display("FAIL midrst_new_req: got lat=%0d data=%h expected lat=10 data=%h", lat, bus_a.data_o, P34);
    end
    n_checks++;
    if (bus_a.rd_cnt_o !== 16'd1 || bus_a.wr_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL midrst_counts: got rd=%0d wr=%0d expected rd=1 wr=0", bus_a.rd_cnt_o, bus_a.wr_cnt_o);
    end
    @(posedge clk_i); #1;
  endtask

  // LATENCY=1 with enable held: acks at E1 and E4, counter pinned at FFFF.
  task automatic test_latency1_saturation();
    logic exp_ack;
    @(negedge clk_i);
    dut_b.memory[3] = PB3;
    dut_b.rd_cnt_q  = 16'hFFFE;
    bus_b.addr_i    = 32'h0000_0060;
    bus_b.write_i   = 1'b0;
    bus_b.enable_i  = 1'b1;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_i); #1;
      exp_ack = (k == 1 || k == 4) ? 1'b1 : 1'b0;
      n_checks++;
      if (bus_b.ack_o !== exp_ack) begin n_fail++; $display("FAIL lat1_ack_e%0d: got %b expected %b", k, bus_b.ack_o, exp_ack); end
      if (k == 1) begin
        n_checks++;
        if (bus_b.data_o !== PB3) begin n_fail++; $display("FAIL lat1_data: got %h expected %h", bus_b.data_o, PB3); end
      end
      if (k == 1 || k == 4) begin
        n_checks++;
        if (bus_b.rd_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL lat1_rd_sat_e%0d: got %h expected ffff", k, bus_b.rd_cnt_o); end
      end
      if (k == 4) bus_b.enable_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    dut.memory[0]  = P0;
    dut.memory[1]  = P1;
    dut.memory[18] = P18;
    dut.memory[32] = P32;
    dut.memory[34] = P34;
    test_read_hit();
    test_back_to_back();
    test_input_churn();
    test_aliasing();
    test_reset_mid_write();
    test_latency1_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
